// File: rtl/weight_read_sequencer.sv
// Read-side walker for the ping-pong weight BRAM: issues every depth address of a layer
// (kernel outer, ci-group middle, co-pair inner) once per pass and aligns index tags with the loader read data.
module weight_read_sequencer #(
    parameter int LITEWIDTH   = 32,
    parameter int COWIDTH     = 10,
    parameter int KWIDTH      = 4,
    parameter int CH_IN       = 16,
    parameter int CH_OUT      = 32,
    parameter int RD_LAT      = 4,
    parameter int WBRAM_DEPTH = 512
) (
    input  logic                 I_clk,
    input  logic                 I_rst_n,
    input  logic                 I_ap_start,
    input  logic [LITEWIDTH-1:0] I_kx_num,
    input  logic [LITEWIDTH-1:0] I_ky_num,
    input  logic [12:0]          I_ciAlign,
    input  logic [12:0]          I_coAlign,
    input  logic [15:0]          I_pass_num,
    input  logic                 I_load_done,
    input  logic                 I_rd_ready,
    output logic [COWIDTH-2:0]   O_rd_wdepth,
    output logic                 O_rd_dv,
    output logic                 O_wt_valid,
    output logic [KWIDTH-1:0]    O_kk_idx,
    output logic [COWIDTH-5:0]   O_cig_idx,
    output logic [COWIDTH-6:0]   O_cog_idx,
    output logic                 O_last,
    output logic                 O_pass_done,
    output logic                 O_layer_done,
    output logic                 O_busy,
    output logic                 O_cfg_err
);

    localparam int AW    = $clog2(WBRAM_DEPTH);
    localparam int KXW   = 2 * LITEWIDTH;
    localparam int TW    = KXW + 26;
    localparam int CI_SH = $clog2(CH_IN);
    localparam int CO_SH = $clog2(CH_OUT);
    localparam int CGW   = COWIDTH - 4;
    localparam int OGW   = COWIDTH - 5;
    localparam int TAGW  = 1 + KWIDTH + CGW + OGW + 1;
    localparam int DW    = $clog2(RD_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP_A, S_SETUP_B, S_WAIT_LOAD, S_RUN, S_DRAIN, S_DONE
    } state_t;

    state_t state_reg, state_next;

    logic           start_d1_reg, start_d2_reg, start_pulse;
    logic [KXW-1:0] kxk_reg;
    logic [12:0]    cig_n_reg, cog_n_reg;
    logic [15:0]    pass_max_reg, pass_cnt_reg;
    logic [AW-1:0]  addr_max_reg, kk_max_reg, cig_max_reg, cog_max_reg;
    logic [AW-1:0]  addr_reg, kk_reg, cig_reg, cog_reg;
    logic [DW-1:0]  drain_cnt_reg;
    logic           cfg_err_reg;
    logic [TW-1:0]  total_calc;
    logic           cfg_bad, addr_last, rd_dv;
    logic [TAGW-1:0] tag_in;

    assign start_pulse = start_d1_reg & ~start_d2_reg;
    assign total_calc  = TW'(kxk_reg) * TW'(cig_n_reg) * TW'(cog_n_reg);
    assign cfg_bad     = (total_calc > TW'(WBRAM_DEPTH)) || (total_calc == '0);
    assign addr_last   = (addr_reg == addr_max_reg);

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            start_d1_reg <= 1'b0;
            start_d2_reg <= 1'b0;
        end else begin
            start_d1_reg <= I_ap_start;
            start_d2_reg <= start_d1_reg;
        end
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // A start pulse from any state restarts the layer; inside a walk it is an abort.
    always_comb begin
        state_next = state_reg;
        if (start_pulse) begin
            state_next = S_SETUP_A;
        end else begin
            case (state_reg)
                S_SETUP_A:   state_next = S_SETUP_B;
                S_SETUP_B:   state_next = cfg_bad ? S_DONE : S_WAIT_LOAD;
                S_WAIT_LOAD: if (I_load_done) state_next = S_RUN;
                S_RUN:       if (I_rd_ready && addr_last && (pass_cnt_reg == pass_max_reg))
                                 state_next = S_DRAIN;
                S_DRAIN:     if (drain_cnt_reg == DW'(RD_LAT - 1)) state_next = S_DONE;
                S_DONE:      state_next = S_IDLE;
                default:     state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        O_busy       = 1'b0;
        rd_dv        = 1'b0;
        O_layer_done = 1'b0;
        case (state_reg)
            S_SETUP_A, S_SETUP_B, S_WAIT_LOAD, S_DRAIN: O_busy = 1'b1;
            S_RUN: begin
                O_busy = 1'b1;
                rd_dv  = I_rd_ready;
            end
            S_DONE:  O_layer_done = 1'b1;
            default: ;
        endcase
    end

    // Products are split over two setup cycles: kxk first, then the full total and limits.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            kxk_reg      <= '0;
            cig_n_reg    <= '0;
            cog_n_reg    <= '0;
            pass_max_reg <= '0;
            addr_max_reg <= '0;
            kk_max_reg   <= '0;
            cig_max_reg  <= '0;
            cog_max_reg  <= '0;
            cfg_err_reg  <= 1'b0;
        end else if (start_pulse) begin
            cfg_err_reg  <= 1'b0;
        end else if (state_reg == S_SETUP_A) begin
            kxk_reg      <= KXW'(I_kx_num) * KXW'(I_ky_num);
            cig_n_reg    <= I_ciAlign >> CI_SH;
            cog_n_reg    <= I_coAlign >> CO_SH;
            pass_max_reg <= (I_pass_num == 16'd0) ? 16'd0 : I_pass_num - 16'd1;
        end else if (state_reg == S_SETUP_B) begin
            addr_max_reg <= AW'(total_calc - TW'(1));
            kk_max_reg   <= AW'(kxk_reg - KXW'(1));
            cig_max_reg  <= AW'(cig_n_reg - 13'd1);
            cog_max_reg  <= AW'(cog_n_reg - 13'd1);
            cfg_err_reg  <= cfg_bad;
        end
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            addr_reg     <= '0;
            kk_reg       <= '0;
            cig_reg      <= '0;
            cog_reg      <= '0;
            pass_cnt_reg <= '0;
        end else if (start_pulse) begin
            addr_reg     <= '0;
            kk_reg       <= '0;
            cig_reg      <= '0;
            cog_reg      <= '0;
            pass_cnt_reg <= '0;
        end else if ((state_reg == S_RUN) && I_rd_ready) begin
            if (addr_last) begin
                addr_reg     <= '0;
                kk_reg       <= '0;
                cig_reg      <= '0;
                cog_reg      <= '0;
                pass_cnt_reg <= pass_cnt_reg + 16'd1;
            end else begin
                addr_reg <= addr_reg + AW'(1);
                if (cog_reg == cog_max_reg) begin
                    cog_reg <= '0;
                    if (cig_reg == cig_max_reg) begin
                        cig_reg <= '0;
                        kk_reg  <= kk_reg + AW'(1);
                    end else begin
                        cig_reg <= cig_reg + AW'(1);
                    end
                end else begin
                    cog_reg <= cog_reg + AW'(1);
                end
            end
        end
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            drain_cnt_reg <= '0;
        end else begin
            drain_cnt_reg <= (state_reg == S_DRAIN) ? drain_cnt_reg + DW'(1) : '0;
        end
    end

    assign O_rd_dv     = rd_dv;
    assign O_rd_wdepth = (COWIDTH - 1)'(addr_reg);
    assign O_cfg_err   = cfg_err_reg;
    assign tag_in      = {rd_dv, kk_reg[KWIDTH-1:0], cig_reg[CGW-1:0], cog_reg[OGW-1:0],
                          rd_dv & addr_last};

    // The loader read path never stalls, so the tag line shifts every cycle regardless of ready.
    for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_tag
        logic [TAGW-1:0] stage_reg;
        logic [TAGW-1:0] stage_in;
        if (gi == 0) begin : g_head
            assign stage_in = tag_in;
        end else begin : g_body
            assign stage_in = g_tag[gi-1].stage_reg;
        end
        always_ff @(posedge I_clk or negedge I_rst_n) begin
            if (!I_rst_n) begin
                stage_reg <= '0;
            end else if (start_pulse) begin
                stage_reg <= '0;
            end else begin
                stage_reg <= stage_in;
            end
        end
    end

    assign {O_wt_valid, O_kk_idx, O_cig_idx, O_cog_idx, O_last} = g_tag[RD_LAT-1].stage_reg;
    assign O_pass_done = O_wt_valid & O_last;

endmodule

// File: tb/tb_weight_read_sequencer.sv
// Scoreboard bench for weight_read_sequencer: every issued read pushes its expected tags,
// which must emerge on the weight side exactly RD_LAT cycles later.
module tb_weight_read_sequencer;

    localparam int RD_LAT = 4;

    logic        I_clk = 1'b0;
    logic        I_rst_n = 1'b0;
    logic        I_ap_start = 1'b0;
    logic [31:0] I_kx_num = '0;
    logic [31:0] I_ky_num = '0;
    logic [12:0] I_ciAlign = '0;
    logic [12:0] I_coAlign = '0;
    logic [15:0] I_pass_num = '0;
    logic        I_load_done = 1'b0;
    logic        I_rd_ready = 1'b0;
    logic [8:0]  O_rd_wdepth;
    logic        O_rd_dv, O_wt_valid, O_last, O_pass_done, O_layer_done, O_busy, O_cfg_err;
    logic [3:0]  O_kk_idx;
    logic [5:0]  O_cig_idx;
    logic [4:0]  O_cog_idx;

    weight_read_sequencer dut (
        .I_clk(I_clk), .I_rst_n(I_rst_n), .I_ap_start(I_ap_start),
        .I_kx_num(I_kx_num), .I_ky_num(I_ky_num), .I_ciAlign(I_ciAlign),
        .I_coAlign(I_coAlign), .I_pass_num(I_pass_num), .I_load_done(I_load_done),
        .I_rd_ready(I_rd_ready), .O_rd_wdepth(O_rd_wdepth), .O_rd_dv(O_rd_dv),
        .O_wt_valid(O_wt_valid), .O_kk_idx(O_kk_idx), .O_cig_idx(O_cig_idx),
        .O_cog_idx(O_cog_idx), .O_last(O_last), .O_pass_done(O_pass_done),
        .O_layer_done(O_layer_done), .O_busy(O_busy), .O_cfg_err(O_cfg_err)
    );

    always #5 I_clk = ~I_clk;

    int cyc = 0;
    always @(posedge I_clk) cyc <= cyc + 1;

    typedef struct {
        int due;
        int kk;
        int cig;
        int cog;
        int last;
    } exp_t;

    exp_t q[$];
    int   total = 0, bad = 0;
    bit   mon_en = 1'b0;
    int   exp_addr = 0, exp_total = 0, exp_cig_n = 1, exp_cog_n = 1;
    int   rd_cnt = 0, pd_cnt = 0, ld_cnt = 0, first_rd = -1, last_rd = -1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rd_dv"}, 32'(O_rd_dv), 0);
        chk({tag, "_wdepth"}, 32'(O_rd_wdepth), 0);
        chk({tag, "_wt_valid"}, 32'(O_wt_valid), 0);
        chk({tag, "_tags"}, 32'({O_kk_idx, O_cig_idx, O_cog_idx, O_last}), 0);
        chk({tag, "_pulses"}, 32'({O_pass_done, O_layer_done}), 0);
        chk({tag, "_busy"}, 32'(O_busy), 0);
        chk({tag, "_cfg_err"}, 32'(O_cfg_err), 0);
    endtask

    // Monitor: push expected tags on each read, pop them when due on the weight side.
    always @(negedge I_clk) begin
        exp_t e;
        if (mon_en) begin
            chk("rd_gate", 32'(O_rd_dv & ~I_rd_ready), 0);
            if (O_rd_dv) begin
                if (exp_total > 0) begin
                    chk("rd_addr", 32'(O_rd_wdepth), exp_addr);
                    e.due  = cyc + RD_LAT;
                    e.cog  = exp_addr % exp_cog_n;
                    e.cig  = (exp_addr / exp_cog_n) % exp_cig_n;
                    e.kk   = exp_addr / (exp_cog_n * exp_cig_n);
                    e.last = (exp_addr == exp_total - 1) ? 1 : 0;
                    q.push_back(e);
                    exp_addr = (exp_addr == exp_total - 1) ? 0 : exp_addr + 1;
                end else begin
                    chk("rd_unexpected", 32'(O_rd_dv), 0);
                end
                if (first_rd < 0) first_rd = cyc;
                last_rd = cyc;
                rd_cnt++;
            end
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                chk("wt_valid", 32'(O_wt_valid), 1);
                chk("kk_idx", 32'(O_kk_idx), e.kk);
                chk("cig_idx", 32'(O_cig_idx), e.cig);
                chk("cog_idx", 32'(O_cog_idx), e.cog);
                chk("last", 32'(O_last), e.last);
                chk("pass_done", 32'(O_pass_done), e.last);
            end else begin
                chk("wt_idle", 32'(O_wt_valid), 0);
                chk("pd_idle", 32'(O_pass_done), 0);
            end
            if (O_pass_done) pd_cnt++;
            if (O_layer_done) ld_cnt++;
        end
    end

    task automatic clear_sb(input int kx, input int ky, input int ci, input int co);
        q.delete();
        exp_total = kx * ky * (ci / 16) * (co / 32);
        exp_cig_n = ci / 16;
        exp_cog_n = co / 32;
        exp_addr = 0; rd_cnt = 0; pd_cnt = 0; ld_cnt = 0; first_rd = -1; last_rd = -1;
        I_kx_num = kx; I_ky_num = ky; I_ciAlign = ci[12:0]; I_coAlign = co[12:0];
    endtask

    // mode 0: ready held high, mode 1: ready toggles every cycle.
    task automatic run_layer(input string name, input int kx, input int ky, input int ci,
                             input int co, input int pn, input int mode, input int load_wait,
                             input int ready_delay, input bit exp_err);
        int np, k, rise;
        np = (pn == 0) ? 1 : pn;
        clear_sb(kx, ky, ci, co);
        rise = -1;
        I_pass_num = pn[15:0];
        I_load_done = (load_wait == 0);
        I_rd_ready = (ready_delay == 0);
        I_ap_start = 1'b1;
        k = 0;
        while (ld_cnt == 0 && k < 3000) begin
            @(posedge I_clk); #1;
            k++;
            if (k == 3) I_ap_start = 1'b0;
            if (load_wait > 0 && k == load_wait) begin
                chk("busy_in_wait", 32'(O_busy), 1);
                chk("rd_in_wait", rd_cnt, 0);
                I_load_done = 1'b1;
                rise = cyc;
            end
            if (k >= ready_delay) I_rd_ready = (mode == 1) ? ~I_rd_ready : 1'b1;
        end
        chk("layer_timeout", 32'(k < 3000), 1);
        repeat (RD_LAT + 2) @(posedge I_clk);
        #1;
        chk("sb_empty", q.size(), 0);
        chk("layer_done_cnt", ld_cnt, 1);
        chk("read_cnt", rd_cnt, exp_err ? 0 : exp_total * np);
        chk("pass_done_cnt", pd_cnt, exp_err ? 0 : np);
        chk("cfg_err", 32'(O_cfg_err), 32'(exp_err));
        chk("busy_after", 32'(O_busy), 0);
        if (rise >= 0) chk("first_rd_lat", first_rd, rise + 1);
        if (mode == 0 && !exp_err) chk("no_gap", last_rd - first_rd + 1, rd_cnt);
        $display("layer %s: reads=%0d pass_done=%0d cfg_err=%0d", name, rd_cnt, pd_cnt, O_cfg_err);
    endtask

    task automatic start_partial(input int stop_addr);
        int k;
        clear_sb(3, 3, 32, 64);
        I_pass_num = 16'd1;
        I_load_done = 1'b1;
        I_rd_ready = 1'b1;
        I_ap_start = 1'b1;
        k = 0;
        while (exp_addr != stop_addr && k < 500) begin
            @(posedge I_clk); #1;
            k++;
            if (k == 3) I_ap_start = 1'b0;
        end
        chk("partial_timeout", 32'(k < 500), 1);
        $display("partial walk stopped at addr %0d after %0d reads", exp_addr, rd_cnt);
    endtask

    initial begin
        repeat (3) @(posedge I_clk);
        #1;
        chk_zero("reset");
        I_rst_n = 1'b1;
        repeat (2) @(posedge I_clk);
        #1;
        mon_en = 1'b1;

        run_layer("basic",    3, 3, 32, 64, 1, 0, 0, 0, 1'b0);
        run_layer("pass3",    3, 3, 32, 64, 3, 0, 0, 0, 1'b0);
        run_layer("toggle",   3, 3, 32, 64, 1, 1, 0, 0, 1'b0);
        run_layer("loadwait", 3, 3, 32, 64, 1, 0, 50, 0, 1'b0);
        run_layer("pass0",    2, 1, 16, 32, 0, 0, 0, 0, 1'b0);
        run_layer("full512",  4, 4, 256, 64, 1, 0, 0, 0, 1'b0);
        run_layer("cfg800",   5, 5, 256, 64, 1, 0, 0, 0, 1'b1);
        run_layer("clr_err",  3, 3, 32, 64, 1, 0, 0, 0, 1'b0);
        run_layer("zero_ci",  3, 3, 0, 64, 1, 0, 0, 0, 1'b1);

        start_partial(10);
        I_rd_ready = 1'b0;
        repeat (8) @(posedge I_clk);
        #1;
        chk("abort_no_pd", pd_cnt, 0);
        run_layer("restart",  3, 3, 32, 64, 1, 0, 0, 6, 1'b0);

        start_partial(20);
        mon_en = 1'b0;
        I_rst_n = 1'b0;
        #1;
        chk_zero("mid_reset");
        repeat (2) @(posedge I_clk);
        #1;
        I_rst_n = 1'b1;
        q.delete();
        mon_en = 1'b1;
        run_layer("post_rst", 3, 3, 32, 64, 2, 0, 0, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/weight_read_sequencer.md
Name: weight_read_sequencer

Overview:
- Read-side controller for the ping-pong weight BRAM fed by the weight loader.
- After a layer's weights are loaded, it walks every weight depth address in the order the loader wrote them: kernel position outer, ci-group middle, co-pair inner.
- Drives the loader's read address and read-valid, with a ready back-pressure from the MAC array.
- Delivers tag-aligned valid and index side-band for the loader's O_weight bus. The full walk can be repeated I_pass_num times per layer (once per feature tile).

Parameters:
- LITEWIDTH, 32, width of AXI-lite config words.
- COWIDTH, 10, channel-count width; depth address is COWIDTH-1 bits.
- KWIDTH, 4, kernel-position counter width.
- CH_IN, 16, input channels per weight beat group.
- CH_OUT, 32, output channels per depth word.
- RD_LAT, 4, cycles from O_rd_wdepth to loader O_weight valid.
- WBRAM_DEPTH, 512, physical depth words per bank.

Ports:
- I_clk  in  1  clock.
- I_rst_n  in  1  asynchronous active-low reset.
- I_ap_start  in  1  layer start level; rising edge is detected internally.
- I_kx_num  in  LITEWIDTH  kernel width.
- I_ky_num  in  LITEWIDTH  kernel height.
- I_ciAlign  in  13  ci count aligned to CH_IN.
- I_coAlign  in  13  co count aligned to CH_OUT.
- I_pass_num  in  16  number of full weight walks for this layer; 0 is treated as 1.
- I_load_done  in  1  loader done level (loader O_load_done).
- I_rd_ready  in  1  consumer accepts one address this cycle.
- O_rd_wdepth  out  COWIDTH-1  read depth address to the loader.
- O_rd_dv  out  1  address valid to the loader (its I_rd_dv).
- O_wt_valid  out  1  loader O_weight is valid this cycle.
- O_kk_idx  out  KWIDTH  kernel-position tag aligned with O_wt_valid.
- O_cig_idx  out  COWIDTH-4  ci-group tag aligned with O_wt_valid.
- O_cog_idx  out  COWIDTH-5  co-pair tag aligned with O_wt_valid.
- O_last  out  1  last word of a pass, aligned with O_wt_valid.
- O_pass_done  out  1  one-cycle pulse when a pass finishes.
- O_layer_done  out  1  one-cycle pulse when all passes finish.
- O_busy  out  1  high from SETUP until DONE.
- O_cfg_err  out  1  sticky error: total depth words exceed WBRAM_DEPTH.

Behaviour:
- Reset: all outputs 0; state IDLE; all counters 0. Asynchronous assert, synchronous deassert use.
- Start detection: I_ap_start is registered twice; a start pulse is issued on the 0->1 transition.
- A start pulse in any state other than IDLE/DONE aborts the current walk: state goes to SETUP, the delay line is flushed, and no O_pass_done or O_layer_done is issued.
- SETUP (2 cycles), with products registered:
  - kxk = I_kx_num*I_ky_num.
  - ciG = I_ciAlign>>log2(CH_IN).
  - coG = I_coAlign>>log2(CH_OUT).
  - total = kxk*ciG*coG.
  - passes = max(I_pass_num,1).
  - If total > WBRAM_DEPTH, or total == 0: set O_cfg_err and go to DONE with no reads.
  - Otherwise go to WAIT_LOAD. O_cfg_err clears on the next start pulse.
- WAIT_LOAD: hold until I_load_done == 1, then go to RUN.
- RUN: O_rd_dv = I_rd_ready.
  - O_rd_wdepth = addr, a linear counter equal to (kk*ciG+cig)*coG+cog.
  - On each cycle with I_rd_ready == 1: addr increments; cog wraps at coG-1 and carries into cig; cig wraps at ciG-1 and carries into kk.
  - I_rd_ready == 0 holds every counter and drives O_rd_dv = 0. O_rd_wdepth keeps its last value.
  - At addr == total-1 with ready: counters reset to 0 and pass_cnt increments.
  - If pass_cnt == passes-1, go to DRAIN; otherwise stay in RUN with no bubble cycle.
- DRAIN: wait RD_LAT cycles, then go to DONE.
- DONE: O_layer_done pulses for 1 cycle, then go to IDLE.
- O_busy is 1 in SETUP, WAIT_LOAD, RUN and DRAIN.
- Tag pipeline: {O_rd_dv, kk, cig, cog, last} is delayed by exactly RD_LAT registers to form O_wt_valid, O_kk_idx, O_cig_idx, O_cog_idx and O_last.
- O_pass_done = O_wt_valid & O_last.
- The tag delay line keeps shifting during back-pressure; it is not stalled, because the loader read path is free-running.
- I_load_done falling during RUN is ignored; the loader only rewrites the other bank.
- Widths: addr, kk, cig and cog counters are sized to hold their maximum values; comparisons are made against registered limits.

Test Plan:
- kx=ky=3, ciAlign=32, coAlign=64, pass=1, ready=1 -> O_rd_wdepth 0..35 on consecutive cycles. O_wt_valid runs 36 cycles, starting 4 cycles after the first read. O_last with kk=8, cig=1, cog=1. One O_pass_done, then O_layer_done.
- Same config, pass=3 -> 108 back-to-back reads with addr wrapping 35->0 and no gap. 3 O_pass_done pulses; O_layer_done after the third.
- Same config, ready toggling 1,0,1,0 -> every address is issued exactly once and in order. O_wt_valid follows each O_rd_dv 4 cycles later; tags match the issued addresses.
- I_load_done held 0 for 50 cycles after start -> no O_rd_dv during the wait. O_busy=1. The first read occurs 1 cycle after load_done rises.
- kx=ky=5, ciAlign=256, coAlign=64 (total=800) -> O_cfg_err=1, no reads, O_layer_done pulse. The next valid start clears O_cfg_err.
- Restart at addr 10 -> reads restart from 0 and no O_pass_done is issued. I_rst_n driven low mid-RUN -> all outputs 0 immediately.
